// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 codes, FSM states, wait counter width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables/data and load extraction/extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_lane_o,
    output logic [31:0] rdata_o,
    output logic        illegal_o,
    output logic        misaligned_o
);

    logic [1:0]  eff_lane;
    logic [31:0] shifted;

    always_comb begin
        // Halfword/word accesses are forced aligned; callers that care flag misalignment.
        eff_lane = 2'b00;
        case (funct3_i[1:0])
            2'b00:   eff_lane = lane_i;
            2'b01:   eff_lane = {lane_i[1], 1'b0};
            default: eff_lane = 2'b00;
        endcase
    end

    always_comb begin
        be_o         = 4'b0000;
        wdata_lane_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                be_o         = 4'b0001 << eff_lane;
                wdata_lane_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be_o         = 4'b0011 << eff_lane;
                wdata_lane_o = {2{wdata_i[15:0]}};
            end
            F3_W:    be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    always_comb begin
        shifted = rword_i >> {eff_lane, 3'b000};
        rdata_o = '0;
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata_o = rword_i;
            F3_BU:   rdata_o = {24'h0, shifted[7:0]};
            F3_HU:   rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = '0;
        endcase
    end

    always_comb begin
        if (we_i) begin
            illegal_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W);
        end else begin
            illegal_o = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W ||
                          funct3_i == F3_BU || funct3_i == F3_HU);
        end
        misaligned_o = (funct3_i[1:0] == 2'b01 && lane_i[0]) ||
                       (funct3_i[1:0] == 2'b10 && lane_i != 2'b00);
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder over an internal word RAM with configurable wait states.
// Define DMEM_ERR_EN to fault misaligned and out-of-range accesses instead of aligning/wrapping.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [31:0] mem [Depth];

    state_e                 state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [2:0]             f3_q, f3_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [ADDR_WIDTH-1:0]  widx;
    logic [31:0]            rword;
    logic [3:0]             be;
    logic [31:0]            wdata_lane;
    logic [31:0]            rdata_ext;
    logic                   illegal;
    logic                   misaligned;
    logic                   access_err;
    logic                   mem_we;

    assign widx  = addr_q[ADDR_WIDTH+1:2];
    assign rword = mem[widx];

    dmem_lane_align u_lane_align (
        .we_i         (we_q),
        .funct3_i     (f3_q),
        .lane_i       (addr_q[1:0]),
        .wdata_i      (wdata_q),
        .rword_i      (rword),
        .be_o         (be),
        .wdata_lane_o (wdata_lane),
        .rdata_o      (rdata_ext),
        .illegal_o    (illegal),
        .misaligned_o (misaligned)
    );

`ifdef DMEM_ERR_EN
    logic out_of_range;
    assign out_of_range = addr_q[31:ADDR_WIDTH+2] != '0;
    assign access_err   = illegal | misaligned | out_of_range;
`else
    // High address bits wrap and alignment is forced, so these are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[31:ADDR_WIDTH+2], misaligned};
    assign access_err       = illegal;
`endif

    // State register and datapath flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            f3_q        <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    state_d = (WAIT_STATES == 0) ? ST_COMMIT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_CNT_W'(WAIT_STATES - 1)) begin
                    state_d = ST_COMMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, commit sampling and the registered response
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == ST_IDLE && req_valid) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            f3_d    = req_funct3;
        end
        if (state_q == ST_COMMIT) begin
            rdata_d = (we_q || access_err) ? 32'h0 : rdata_ext;
            err_d   = access_err;
        end
        // Valid is flopped one cycle into RESP so the channel is driven purely from flops.
        rsp_valid_d = (state_q == ST_RESP) && !(rsp_valid_q && rsp_ready);
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = rsp_valid_q;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    assign mem_we = (state_q == ST_COMMIT) && we_q && !access_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

endmodule
